axis_stream_bridge: RTL

Parametrised successor to the single-transaction DMA bridge. It sits between the AXI-Stream DMA channels and a compute core. On the input side it parses a count header, feeds exactly N elements to the core with backpressure, and polices packet length. On the output side it buffers core results in a DEPTH-entry FIFO and emits exactly M beats, with TLAST on the M-th beat rather than on a separate null beat.

---
 rtl/axis_stream_bridge_if.sv | 13 +
 rtl/axis_stream_bridge.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/axis_stream_bridge_if.sv
// AXI-Stream channel bundle shared by the input and output sides of the bridge.
interface axis_stream_bridge_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_stream_bridge.sv
// Stream bridge: parses a count header, feeds N elements to the core, and returns
// exactly M buffered results with TLAST on the final beat.
module axis_stream_bridge #(
  parameter int DATA_W   = 32,
  parameter int ELEM_W   = 16,
  parameter int CNT_W    = 16,
  parameter int DEPTH    = 4,
  parameter int SIGN_EXT = 0
) (
  input  logic                AXIS_ACLK,
  input  logic                AXIS_ARESET,
  axis_stream_bridge_if.slave  s_axis,
  axis_stream_bridge_if.master m_axis,
  output logic [ELEM_W-1:0]   core_x,
  output logic                core_x_valid,
  input  logic                core_ready,
  input  logic [ELEM_W-1:0]   core_y,
  input  logic                core_y_valid,
  output logic                core_y_ready,
  input  logic [CNT_W-1:0]    core_ocnt,
  input  logic                core_ocnt_valid,
  output logic                busy,
  output logic                err_short,
  output logic                err_long,
  output logic                err_overrun
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {ST_HDR, ST_DATA, ST_DRAIN, ST_WAIT} state_t;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         in_left, out_left, push_left, hdr_n;
  logic                     cnt_held, out_done;
  logic [DEPTH-1:0][ELEM_W-1:0] mem;
  logic [AW-1:0]            wptr, rptr;
  logic [AW:0]              fifo_cnt;
  logic                     rx, tx, push, pop, fifo_empty, zero_beat, head_vld;
  logic                     y_ok, latch_cnt, overrun, done_set;
  logic                     set_short, set_long, done_clr;
  logic [ELEM_W-1:0]        head;
  logic [DATA_W-1:0]        head_ext;
  logic                     unused_ok;

  assign unused_ok = ^{s_axis.tkeep, s_axis.tdata};

  // ---------------- input side ----------------
  assign hdr_n = s_axis.tdata[CNT_W-1:0];
  assign s_axis.tready = !AXIS_ARESET &&
                         (state == ST_HDR || (state == ST_DATA && core_ready) || state == ST_DRAIN);
  assign rx = s_axis.tvalid & s_axis.tready;

  always_comb begin
    state_nxt = state;
    set_short = 1'b0;
    set_long  = 1'b0;
    done_clr  = 1'b0;
    case (state)
      ST_HDR: if (rx) begin
        if (s_axis.tlast) begin
          state_nxt = ST_WAIT;
          set_short = (hdr_n != '0);
        end else if (hdr_n == '0) state_nxt = ST_DRAIN;
        else                      state_nxt = ST_DATA;
      end
      ST_DATA: if (rx) begin
        if (in_left == ONE)     state_nxt = s_axis.tlast ? ST_WAIT : ST_DRAIN;
        else if (s_axis.tlast) begin
          state_nxt = ST_WAIT;
          set_short = 1'b1;
        end
      end
      ST_DRAIN: if (rx) begin
        set_long = 1'b1;
        if (s_axis.tlast) state_nxt = ST_WAIT;
      end
      ST_WAIT: if (out_done) begin
        state_nxt = ST_HDR;
        done_clr  = 1'b1;
      end
      default: state_nxt = ST_HDR;
    endcase
  end

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      state        <= ST_HDR;
      in_left      <= '0;
      core_x       <= '0;
      core_x_valid <= 1'b0;
      err_short    <= 1'b0;
      err_long     <= 1'b0;
    end else begin
      state        <= state_nxt;
      core_x_valid <= rx && (state == ST_DATA);
      if (rx && state == ST_HDR)  in_left <= hdr_n;
      if (rx && state == ST_DATA) begin
        in_left <= in_left - 1'b1;
        core_x  <= s_axis.tdata[ELEM_W-1:0];
      end
      if (set_short) err_short <= 1'b1;
      if (set_long)  err_long  <= 1'b1;
    end
  end

  // ---------------- output side ----------------
  assign fifo_empty   = (fifo_cnt == '0);
  assign zero_beat    = cnt_held && (out_left == '0);
  assign head_vld     = cnt_held && !fifo_empty;
  assign core_y_ready = !AXIS_ARESET && (fifo_cnt != FULL);
  assign y_ok         = cnt_held && (push_left != '0);
  assign push         = core_y_valid && core_y_ready && y_ok;
  assign overrun      = core_y_valid && !y_ok;
  assign latch_cnt    = core_ocnt_valid && !cnt_held;
  assign head         = mem[rptr];

  generate
    if (SIGN_EXT != 0) begin : g_sext
      assign head_ext = DATA_W'($signed(head));
    end else begin : g_zext
      assign head_ext = DATA_W'(head);
    end
  endgenerate

  // A latched M of zero is answered with a single empty TLAST beat.
  assign m_axis.tvalid = head_vld || zero_beat;
  assign m_axis.tdata  = head_vld ? head_ext : '0;
  assign m_axis.tkeep  = head_vld ? '1 : '0;
  assign m_axis.tlast  = zero_beat || (out_left == ONE);

  assign tx       = m_axis.tvalid && m_axis.tready;
  assign pop      = tx && !zero_beat;
  assign done_set = tx && (zero_beat || out_left == ONE);

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      mem         <= '0;
      wptr        <= '0;
      rptr        <= '0;
      fifo_cnt    <= '0;
      out_left    <= '0;
      push_left   <= '0;
      cnt_held    <= 1'b0;
      out_done    <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= core_y;
        wptr      <= wptr + 1'b1;
        push_left <= push_left - 1'b1;
      end
      if (pop) begin
        rptr     <= rptr + 1'b1;
        out_left <= out_left - 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (latch_cnt) begin
        out_left  <= core_ocnt;
        push_left <= core_ocnt;
        cnt_held  <= 1'b1;
      end
      if (done_set) cnt_held <= 1'b0;
      if (done_clr) out_done <= 1'b0;
      if (done_set) out_done <= 1'b1;
      if (overrun)  err_overrun <= 1'b1;
    end
  end

  assign busy = (state != ST_HDR) || (out_left != '0) || !fifo_empty;
endmodule
